// File: rtl/branch_resolver_if.sv
// Bundle of prediction, resolution and update signals between the fetch/execute
// stages and the branch resolver. No clock lives here; clk and rst are plain ports.
//
// Handshake: a prediction record transfers on a rising edge where pred_valid=1,
// pred_ready=1 and flush=0. pred_ready depends only on the registered occupancy.
// res_valid has no ready; it is taken on any edge where flush=0. flush,
// redirect_pc, upd_* are one-cycle-delayed registered results of that edge.
interface branch_resolver_if;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_ctr;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_write;
    logic [31:0] upd_pc;
    logic [1:0]  upd_ctr;
    logic [31:0] upd_target;
    logic [2:0]  occupancy;
    logic [15:0] mispredict_cnt;
    logic        err_underflow;

    // Fetch/execute side: drives predictions and resolutions.
    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target, pred_ctr,
        output res_valid, res_taken, res_target,
        input  pred_ready, flush, redirect_pc, upd_write, upd_pc, upd_ctr,
        input  upd_target, occupancy, mispredict_cnt, err_underflow
    );

    // Resolver side.
    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target, pred_ctr,
        input  res_valid, res_taken, res_target,
        output pred_ready, flush, redirect_pc, upd_write, upd_pc, upd_ctr,
        output upd_target, occupancy, mispredict_cnt, err_underflow
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: holds up to four in-flight prediction records in order,
// compares the oldest against the execute-stage outcome, and emits table updates,
// pipeline flushes and a misprediction count.
module branch_resolver (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  ctr;
    } rec_t;

    rec_t        r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        r_flush;
    logic [31:0] r_redirect_pc;
    logic        r_upd_write;
    logic [31:0] r_upd_pc;
    logic [1:0]  r_upd_ctr;
    logic [31:0] r_upd_target;
    logic [15:0] r_mispredict_cnt;
    logic        r_err_underflow;

    rec_t        w_head;
    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_underflow;
    logic        w_mispred;
    logic        w_flush_pop;
    logic [1:0]  w_ctr_next;
    logic [31:0] w_redirect;

    // Decode this cycle's push/pop/mispredict; the flush cycle blocks everything.
    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_ready     = (r_count < 3'd4);
        w_push      = bus.pred_valid && w_ready && !r_flush;
        w_pop       = bus.res_valid && (r_count != 3'd0) && !r_flush;
        w_underflow = bus.res_valid && (r_count == 3'd0) && !r_flush;
        w_mispred   = (w_head.taken != bus.res_taken) ||
                      (w_head.taken && bus.res_taken && (w_head.target != bus.res_target));
        w_flush_pop = w_pop && w_mispred;
        w_ctr_next  = w_head.ctr;
        if (bus.res_taken) begin
            if (w_head.ctr != 2'd3) w_ctr_next = w_head.ctr + 2'd1;
        end else begin
            if (w_head.ctr != 2'd0) w_ctr_next = w_head.ctr - 2'd1;
        end
        w_redirect  = bus.res_taken ? bus.res_target : (w_head.pc + 32'd4);
    end

    // Record storage; stale entries are harmless because pointers govern validity.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush_pop) begin
            r_mem[r_wr_ptr] <= '{pc: bus.pred_pc, taken: bus.pred_taken,
                                 target: bus.pred_target, ctr: bus.pred_ctr};
        end
    end

    // Queue pointers and occupancy; a mispredict empties the queue, dropping any
    // younger records and the same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else if (w_flush_pop) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Registered results of a pop: table update, flush/redirect, counters, error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush          <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_upd_write      <= 1'b0;
            r_upd_pc         <= 32'd0;
            r_upd_ctr        <= 2'd0;
            r_upd_target     <= 32'd0;
            r_mispredict_cnt <= 16'd0;
            r_err_underflow  <= 1'b0;
        end else begin
            r_flush     <= w_flush_pop;
            r_upd_write <= w_pop;
            if (w_pop) begin
                r_upd_pc     <= w_head.pc;
                r_upd_ctr    <= w_ctr_next;
                r_upd_target <= bus.res_target;
            end
            if (w_flush_pop) begin
                r_redirect_pc <= w_redirect;
                if (r_mispredict_cnt != 16'hFFFF) r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
            end
            if (w_underflow) r_err_underflow <= 1'b1;
        end
    end

    assign bus.pred_ready     = w_ready;
    assign bus.occupancy      = r_count;
    assign bus.flush          = r_flush;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.upd_write      = r_upd_write;
    assign bus.upd_pc         = r_upd_pc;
    assign bus.upd_ctr        = r_upd_ctr;
    assign bus.upd_target     = r_upd_target;
    assign bus.mispredict_cnt = r_mispredict_cnt;
    assign bus.err_underflow  = r_err_underflow;
endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the resolver's behaviour.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if bif ();

  branch_resolver dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  ctr;
  } rec_t;

  rec_t        exp_q[$];
  logic        m_flush;
  logic [31:0] m_redirect;
  logic        m_upd_write;
  logic [31:0] m_upd_pc;
  logic [1:0]  m_upd_ctr;
  logic [31:0] m_upd_target;
  int          m_mis;
  logic        m_err;

  task automatic model_reset();
    exp_q.delete();
    m_flush = 0; m_redirect = 0; m_upd_write = 0; m_upd_pc = 0;
    m_upd_ctr = 0; m_upd_target = 0; m_mis = 0; m_err = 0;
  endtask

  // Apply one rising edge to the model using the inputs the bench is driving.
  task automatic model_edge();
    bit   was_flush = m_flush;
    bit   ready = (exp_q.size() < 4);
    bit   pop   = bif.res_valid && exp_q.size() > 0 && !was_flush;
    bit   push  = bif.pred_valid && ready && !was_flush;
    rec_t h;
    rec_t n;
    bit   mis;
    int   c;
    n.pc = bif.pred_pc; n.taken = bif.pred_taken;
    n.target = bif.pred_target; n.ctr = bif.pred_ctr;
    if (bif.res_valid && exp_q.size() == 0 && !was_flush) m_err = 1;
    m_flush = 0;
    m_upd_write = pop;
    if (pop) begin
      h = exp_q.pop_front();
      mis = (h.taken != bif.res_taken) ||
            (h.taken && bif.res_taken && h.target != bif.res_target);
      c = int'(h.ctr) + (bif.res_taken ? 1 : -1);
      if (c > 3) c = 3;
      if (c < 0) c = 0;
      m_upd_pc = h.pc;
      m_upd_ctr = c[1:0];
      m_upd_target = bif.res_target;
      if (mis) begin
        m_flush = 1;
        m_redirect = bif.res_taken ? bif.res_target : h.pc + 32'd4;
        if (m_mis < 65535) m_mis++;
        exp_q.delete();
        push = 0;
      end
    end
    if (push) exp_q.push_back(n);
  endtask

  task automatic drive_idle();
    bif.pred_valid = 0; bif.pred_pc = 0; bif.pred_taken = 0; bif.pred_target = 0;
    bif.pred_ctr = 0; bif.res_valid = 0; bif.res_taken = 0; bif.res_target = 0;
  endtask

  // One clock cycle: drive at negedge, model and DUT advance at posedge, settle 1 unit.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic [1:0] pcr,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    @(negedge clk);
    bif.pred_valid = pv; bif.pred_pc = ppc; bif.pred_taken = pt;
    bif.pred_target = ptg; bif.pred_ctr = pcr;
    bif.res_valid = rv; bif.res_taken = rt; bif.res_target = rtg;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bif.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", bif.occupancy); end
    checks++; if (bif.pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bif.pred_ready); end
    checks++; if (bif.flush !== 1'b0 || bif.upd_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got flush=%b upd=%b want 0/0", bif.flush, bif.upd_write); end
    checks++; if (bif.redirect_pc !== 32'd0 || bif.upd_pc !== 32'd0 || bif.upd_target !== 32'd0 || bif.upd_ctr !== 2'd0) begin
      errors++; $display("FAIL reset_data got rd=%h pc=%h tg=%h ctr=%0d want zeros", bif.redirect_pc, bif.upd_pc, bif.upd_target, bif.upd_ctr); end
    checks++; if (bif.mispredict_cnt !== 16'd0 || bif.err_underflow !== 1'b0) begin errors++; $display("FAIL reset_cnt got cnt=%0d err=%b want 0/0", bif.mispredict_cnt, bif.err_underflow); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_correct_taken();
    do_reset();
    step(1, 32'h100, 1, 32'h200, 2'd2, 0, 0, 0);
    checks++; if (bif.occupancy !== 3'd1) begin errors++; $display("FAIL first_push_occ got %0d want 1", bif.occupancy); end
    step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    checks++; if (bif.upd_write !== 1'b1 || bif.upd_ctr !== 2'd3) begin errors++; $display("FAIL correct_upd got wr=%b ctr=%0d want 1/3", bif.upd_write, bif.upd_ctr); end
    checks++; if (bif.upd_pc !== 32'h100 || bif.upd_target !== 32'h200) begin errors++; $display("FAIL correct_upd_data got pc=%h tg=%h want 100/200", bif.upd_pc, bif.upd_target); end
    checks++; if (bif.flush !== 1'b0 || bif.occupancy !== 3'd0) begin errors++; $display("FAIL correct_flush got flush=%b occ=%0d want 0/0", bif.flush, bif.occupancy); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bif.upd_write !== 1'b0 || bif.upd_pc !== 32'h100) begin errors++; $display("FAIL upd_hold got wr=%b pc=%h want 0/100", bif.upd_write, bif.upd_pc); end
  endtask

  task automatic test_direction_mispredict();
    do_reset();
    step(1, 32'h100, 1, 32'h500, 2'd3, 0, 0, 0);
    step(1, 32'h104, 0, 32'h0,   2'd1, 0, 0, 0);
    step(1, 32'h108, 0, 32'h0,   2'd1, 0, 0, 0);
    step(1, 32'h10C, 0, 32'h0,   2'd1, 1, 0, 32'h999);
    checks++; if (bif.flush !== 1'b1 || bif.redirect_pc !== 32'h104) begin errors++; $display("FAIL dir_mis_flush got flush=%b rd=%h want 1/104", bif.flush, bif.redirect_pc); end
    checks++; if (bif.upd_ctr !== 2'd2 || bif.occupancy !== 3'd0) begin errors++; $display("FAIL dir_mis_state got ctr=%0d occ=%0d want 2/0", bif.upd_ctr, bif.occupancy); end
    checks++; if (bif.mispredict_cnt !== 16'd1) begin errors++; $display("FAIL dir_mis_cnt got %0d want 1", bif.mispredict_cnt); end
    // Wrong-path cycle: both inputs must be ignored.
    step(1, 32'h110, 0, 32'h0, 2'd0, 1, 0, 32'h0);
    checks++; if (bif.flush !== 1'b0 || bif.upd_write !== 1'b0 || bif.occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_cycle got flush=%b wr=%b occ=%0d want 0/0/0", bif.flush, bif.upd_write, bif.occupancy); end
    checks++; if (bif.err_underflow !== 1'b0 || bif.redirect_pc !== 32'h104) begin errors++; $display("FAIL flush_cycle_err got err=%b rd=%h want 0/104", bif.err_underflow, bif.redirect_pc); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 2'd1, 0, 0, 0);
    checks++; if (bif.pred_ready !== 1'b0 || bif.occupancy !== 3'd4) begin errors++; $display("FAIL full got ready=%b occ=%0d want 0/4", bif.pred_ready, bif.occupancy); end
    step(1, 32'h210, 0, 0, 2'd1, 0, 0, 0);
    checks++; if (bif.occupancy !== 3'd4) begin errors++; $display("FAIL fifth_push got occ=%0d want 4", bif.occupancy); end
    step(1, 32'h214, 0, 0, 2'd1, 1, 0, 32'h0);
    checks++; if (bif.occupancy !== 3'd3 || bif.upd_pc !== 32'h200 || bif.upd_ctr !== 2'd0) begin
      errors++; $display("FAIL full_push_pop got occ=%0d pc=%h ctr=%0d want 3/200/0", bif.occupancy, bif.upd_pc, bif.upd_ctr); end
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 32'h0);
      checks++; if (bif.upd_pc !== 32'h200 + 32'(4 * i) || bif.flush !== 1'b0) begin
        errors++; $display("FAIL drain_order got pc=%h flush=%b want %h/0", bif.upd_pc, bif.flush, 32'h200 + 32'(4 * i)); end
    end
    checks++; if (bif.occupancy !== 3'd0 || bif.pred_ready !== 1'b1) begin errors++; $display("FAIL drained got occ=%0d ready=%b want 0/1", bif.occupancy, bif.pred_ready); end
  endtask

  task automatic test_target_mispredict();
    do_reset();
    step(1, 32'h120, 1, 32'h300, 2'd1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h340);
    checks++; if (bif.flush !== 1'b1 || bif.redirect_pc !== 32'h340 || bif.upd_target !== 32'h340) begin
      errors++; $display("FAIL tgt_mis got flush=%b rd=%h tg=%h want 1/340/340", bif.flush, bif.redirect_pc, bif.upd_target); end
    checks++; if (bif.upd_ctr !== 2'd2 || bif.mispredict_cnt !== 16'd1) begin errors++; $display("FAIL tgt_mis_ctr got ctr=%0d cnt=%0d want 2/1", bif.upd_ctr, bif.mispredict_cnt); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1, 32'h40);
    checks++; if (bif.err_underflow !== 1'b1 || bif.upd_write !== 1'b0 || bif.flush !== 1'b0) begin
      errors++; $display("FAIL underflow got err=%b wr=%b flush=%b want 1/0/0", bif.err_underflow, bif.upd_write, bif.flush); end
    step(1, 32'h80, 0, 0, 2'd0, 0, 0, 0);
    checks++; if (bif.err_underflow !== 1'b1 || bif.occupancy !== 3'd1) begin errors++; $display("FAIL underflow_sticky got err=%b occ=%0d want 1/1", bif.err_underflow, bif.occupancy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4 * i), 1, 32'h800, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h800);
    #2;
    rst = 0;
    #1;
    checks++; if (bif.occupancy !== 3'd0 || bif.pred_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_occ got occ=%0d ready=%b want 0/1", bif.occupancy, bif.pred_ready); end
    checks++; if (bif.upd_write !== 1'b0 || bif.upd_pc !== 32'd0 || bif.upd_ctr !== 2'd0 || bif.upd_target !== 32'd0) begin
      errors++; $display("FAIL mid_reset_upd got wr=%b pc=%h ctr=%0d tg=%h want zeros", bif.upd_write, bif.upd_pc, bif.upd_ctr, bif.upd_target); end
    model_reset();
    @(negedge clk);
    drive_idle();
    rst = 1;
    step(0, 0, 0, 0, 0, 1, 0, 32'h0);
    checks++; if (bif.upd_write !== 1'b0 || bif.flush !== 1'b0 || bif.occupancy !== 3'd0) begin
      errors++; $display("FAIL post_reset got wr=%b flush=%b occ=%0d want 0/0/0", bif.upd_write, bif.flush, bif.occupancy); end
  endtask

  task automatic test_random();
    logic [31:0] tg_set [4];
    tg_set[0] = 32'h1000; tg_set[1] = 32'h2000; tg_set[2] = 32'h3000; tg_set[3] = 32'hFFFF_FFFC;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, {$urandom(), 2'b00} | 32'hFFFF_FF00 * $urandom_range(0, 1),
           1'($urandom_range(0, 1)), tg_set[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)), tg_set[$urandom_range(0, 3)]);
      checks++;
      if (bif.occupancy !== 3'(exp_q.size()) || bif.pred_ready !== (exp_q.size() < 4) ||
          bif.flush !== m_flush || bif.redirect_pc !== m_redirect ||
          bif.upd_write !== m_upd_write || bif.upd_pc !== m_upd_pc ||
          bif.upd_ctr !== m_upd_ctr || bif.upd_target !== m_upd_target ||
          bif.mispredict_cnt !== 16'(m_mis) || bif.err_underflow !== m_err) begin
        errors++;
        $display("FAIL random cyc=%0d got occ=%0d fl=%b rd=%h wr=%b pc=%h ctr=%0d tg=%h cnt=%0d err=%b want occ=%0d fl=%b rd=%h wr=%b pc=%h ctr=%0d tg=%h cnt=%0d err=%b",
                 n, bif.occupancy, bif.flush, bif.redirect_pc, bif.upd_write, bif.upd_pc, bif.upd_ctr,
                 bif.upd_target, bif.mispredict_cnt, bif.err_underflow, exp_q.size(), m_flush, m_redirect,
                 m_upd_write, m_upd_pc, m_upd_ctr, m_upd_target, m_mis, m_err);
      end
    end
  endtask

  initial begin
    rst = 0;
    drive_idle();
    model_reset();
    test_reset();
    test_correct_taken();
    test_direction_mispredict();
    test_full();
    test_target_mispredict();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 pred_valid  input  1  fetch stage issues a prediction record this cycle.
REQ-004 pred_pc  input  32  PC of the predicted branch.
REQ-005 pred_taken  input  1  predicted direction.
REQ-006 pred_target  input  32  predicted target; meaningful only when pred_taken=1.
REQ-007 pred_ctr  input  2  2-bit history counter value read at prediction time.
REQ-008 pred_ready  output  1  queue can accept a record.
REQ-009 res_valid  input  1  execute stage resolves the oldest in-flight branch.
REQ-010 res_taken  input  1  actual direction.
REQ-011 res_target  input  32  actual computed target.
REQ-012 flush  output  1  one-cycle pipeline flush pulse.
REQ-013 redirect_pc  output  32  correct fetch PC; valid while flush=1.
REQ-014 upd_write  output  1  one-cycle write strobe to history/target tables.
REQ-015 upd_pc  output  32  table index PC for the update.
REQ-016 upd_ctr  output  2  new counter value to write.
REQ-017 upd_target  output  32  target to write into target buffer.
REQ-018 occupancy  output  3  records in flight, 0..4.
REQ-019 mispredict_cnt  output  16  total mispredictions.
REQ-020 err_underflow  output  1  sticky: res_valid seen with empty queue.

Function
REQ-021 Record queue SHALL be in-order FIFO, depth 4, fields {pc, taken, target, ctr}; pointers wrap modulo 4.
REQ-022 pred_ready SHALL be 1 iff registered occupancy < 4; decided from registered count only (full queue refuses push even with same-cycle pop).
REQ-023 Push SHALL occur when pred_valid=1, pred_ready=1, flush=0; otherwise record dropped silently.
REQ-024 Pop of head SHALL occur when res_valid=1, occupancy>0, flush=0.
REQ-025 Mispredict SHALL be: head.taken != res_taken, or (head.taken=1 and res_taken=1 and head.target != res_target).
REQ-026 All outputs except pred_ready, occupancy SHALL be registered: latency exactly 1 cycle from resolving edge.
REQ-027 Every pop SHALL produce upd_write=1 next cycle with upd_pc=head.pc, upd_target=res_target.
REQ-028 upd_ctr SHALL be head.ctr+1 saturating at 3 if res_taken=1, head.ctr-1 saturating at 0 if res_taken=0.
REQ-029 On mispredict pop: flush=1 next cycle; redirect_pc=res_target if res_taken=1, else head.pc+4 (32-bit wrap).
REQ-030 On mispredict pop, all younger records SHALL be discarded at the same edge (occupancy becomes 0); a same-cycle push SHALL be discarded too.
REQ-031 On correct pop: flush=0, queue keeps remaining records; same-cycle push accepted if pred_ready=1.
REQ-032 While flush=1, pred_valid and res_valid SHALL be ignored (wrong-path cycle), and err_underflow not set.
REQ-033 res_valid with occupancy=0 and flush=0 SHALL set err_underflow, no update, no flush.
REQ-034 mispredict_cnt SHALL increment by 1 per mispredict pop, saturating at 0xFFFF.
REQ-035 redirect_pc SHALL hold last value when flush=0; upd_* data hold when upd_write=0.

Reset
REQ-036 rst=0 SHALL immediately clear: pointers, occupancy=0, pred_ready=1, flush=0, redirect_pc=0, upd_write=0, upd_pc=0, upd_ctr=0, upd_target=0, mispredict_cnt=0, err_underflow=0.
REQ-037 Reset mid-operation SHALL drop all in-flight records; no update or flush issued after release.
REQ-038 First push accepted on first rising edge with rst=1.

Verification
REQ-039 Push pc=0x100 taken=1 tgt=0x200 ctr=2; resolve taken tgt=0x200 -> next cycle upd_write=1 upd_ctr=3, flush=0, occupancy=0.
REQ-040 Push pc=0x100 taken=1 ctr=3, push 0x104, 0x108; resolve not-taken -> flush=1 redirect_pc=0x104, upd_ctr=2, occupancy=0, mispredict_cnt=1.
REQ-041 Push 4 records -> pred_ready=0; 5th push dropped; push+correct pop same cycle when full -> occupancy=3.
REQ-042 Predicted taken tgt=0x300, actual taken tgt=0x340 -> flush=1 redirect_pc=0x340, upd_target=0x340.
REQ-043 res_valid with empty queue -> err_underflow=1 sticky, upd_write=0; res_valid/pred_valid in flush cycle -> no effect.
REQ-044 Assert rst=0 with 3 records queued between edges -> outputs cleared immediately, occupancy=0 after release.
